// File: rtl/udp_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UDP header + AXI-Stream payload
// transmit path between NUM_PORTS requesters, with per-port packet/error counters.
module udp_tx_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int HDR_WIDTH  = 112,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*HDR_WIDTH-1:0]  s_hdr_data,
  input  logic [NUM_PORTS-1:0]            s_hdr_valid,
  output logic [NUM_PORTS-1:0]            s_hdr_ready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_payload_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_payload_tkeep,
  input  logic [NUM_PORTS-1:0]            s_payload_tlast,
  input  logic [NUM_PORTS-1:0]            s_payload_tuser,
  input  logic [NUM_PORTS-1:0]            s_payload_tvalid,
  output logic [NUM_PORTS-1:0]            s_payload_tready,
  output logic [HDR_WIDTH-1:0]            m_hdr_data,
  output logic                            m_hdr_valid,
  input  logic                            m_hdr_ready,
  output logic [DATA_WIDTH-1:0]           m_payload_tdata,
  output logic [KEEP_WIDTH-1:0]           m_payload_tkeep,
  output logic                            m_payload_tlast,
  output logic                            m_payload_tuser,
  output logic                            m_payload_tvalid,
  input  logic                            m_payload_tready,
  output logic [NUM_PORTS-1:0]            grant_onehot,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_count,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  err_count
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, HDR, PLD} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] g, next_g, lg, pick, cand;
  logic             any_req, hdr_fire, pld_last_fire;
  logic [CNT_WIDTH-1:0] pkt_cnt [NUM_PORTS];
  logic [CNT_WIDTH-1:0] err_cnt [NUM_PORTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g     <= '0;
      lg    <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state <= next_state;
      g     <= next_g;
      if (pld_last_fire) lg <= g;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt[i] <= '0;
        err_cnt[i] <= '0;
      end
    end else if (pld_last_fire) begin
      pkt_cnt[g] <= pkt_cnt[g] + CNT_WIDTH'(1);
      if (m_payload_tuser) err_cnt[g] <= err_cnt[g] + CNT_WIDTH'(1);
    end
  end

  // Scan from the farthest candidate back to lg+1 so the nearest requester wins.
  always_comb begin
    any_req = |s_hdr_valid;
    pick    = lg;
    cand    = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = IDX_W'((int'(lg) + k) % NUM_PORTS);
      if (s_hdr_valid[cand]) pick = cand;
    end
  end

  always_comb begin
    next_state = state;
    next_g     = g;
    case (state)
      IDLE: if (any_req) begin
        next_g     = pick;
        next_state = HDR;
      end
      HDR:     if (hdr_fire) next_state = PLD;
      PLD:     if (pld_last_fire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    m_hdr_data       = s_hdr_data[int'(g)*HDR_WIDTH +: HDR_WIDTH];
    m_payload_tdata  = s_payload_tdata[int'(g)*DATA_WIDTH +: DATA_WIDTH];
    m_payload_tkeep  = s_payload_tkeep[int'(g)*KEEP_WIDTH +: KEEP_WIDTH];
    m_payload_tlast  = s_payload_tlast[g];
    m_payload_tuser  = s_payload_tuser[g];
    m_hdr_valid      = 1'b0;
    m_payload_tvalid = 1'b0;
    s_hdr_ready      = '0;
    s_payload_tready = '0;
    grant_onehot     = '0;
    case (state)
      HDR: begin
        m_hdr_valid     = s_hdr_valid[g];
        s_hdr_ready[g]  = m_hdr_ready;
        grant_onehot[g] = 1'b1;
      end
      PLD: begin
        m_payload_tvalid    = s_payload_tvalid[g];
        s_payload_tready[g] = m_payload_tready;
        grant_onehot[g]     = 1'b1;
      end
      default: ;
    endcase
  end

  assign hdr_fire      = (state == HDR) && m_hdr_valid && m_hdr_ready;
  assign pld_last_fire = (state == PLD) && m_payload_tvalid && m_payload_tready && m_payload_tlast;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    assign pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt[i];
    assign err_count[i*CNT_WIDTH +: CNT_WIDTH] = err_cnt[i];
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomized bench for udp_tx_arbiter: packet sources per port, a packet-level
// round-robin reference model and a per-cycle comparison of all outputs.
module tb_udp_tx_arbiter;

  localparam int NP = 3;
  localparam int HW = 112;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int CW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NP*HW-1:0]  s_hdr_data;
  logic [NP-1:0]     s_hdr_valid, s_hdr_ready;
  logic [NP*DW-1:0]  s_payload_tdata;
  logic [NP*KW-1:0]  s_payload_tkeep;
  logic [NP-1:0]     s_payload_tlast, s_payload_tuser, s_payload_tvalid, s_payload_tready;
  logic [HW-1:0]     m_hdr_data;
  logic              m_hdr_valid, m_hdr_ready;
  logic [DW-1:0]     m_payload_tdata;
  logic [KW-1:0]     m_payload_tkeep;
  logic              m_payload_tlast, m_payload_tuser, m_payload_tvalid, m_payload_tready;
  logic [NP-1:0]     grant_onehot;
  logic [NP*CW-1:0]  pkt_count, err_count;

  udp_tx_arbiter #(
    .NUM_PORTS(NP), .HDR_WIDTH(HW), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_hdr_data(s_hdr_data), .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
    .s_payload_tdata(s_payload_tdata), .s_payload_tkeep(s_payload_tkeep),
    .s_payload_tlast(s_payload_tlast), .s_payload_tuser(s_payload_tuser),
    .s_payload_tvalid(s_payload_tvalid), .s_payload_tready(s_payload_tready),
    .m_hdr_data(m_hdr_data), .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
    .m_payload_tdata(m_payload_tdata), .m_payload_tkeep(m_payload_tkeep),
    .m_payload_tlast(m_payload_tlast), .m_payload_tuser(m_payload_tuser),
    .m_payload_tvalid(m_payload_tvalid), .m_payload_tready(m_payload_tready),
    .grant_onehot(grant_onehot), .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Source side: one packet in flight per port
  bit             has_pkt [NP];
  bit             hdr_sent[NP];
  bit             last_user[NP];
  int             nbeats[NP];
  int             beat[NP];
  int             seq[NP];
  logic [HW-1:0]  hdr[NP];
  logic [15:0]    salt[NP];
  logic [KW-1:0]  last_keep[NP];

  int p_new = 0, p_tv = 100, p_hr = 100, p_pr = 100, p_err = 30, fixed_len = 0;
  bit toggle_pr = 1'b0, stray = 1'b0;

  // Reference model: who owns the output, whether its header went out, last winner, counts
  int             owner = -1;
  bit             in_pld = 1'b0;
  int             model_lg = NP - 1;
  logic [CW-1:0]  mpkt[NP];
  logic [CW-1:0]  merr[NP];

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW+KW+1:0] beat_fields(input int p, input int b);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [3:0]    bi;
    bit            lst;
    logic          u;
    bi  = b[3:0];
    d   = {8'(p), 24'(seq[p]), 16'(b), salt[p]};
    lst = (b == nbeats[p] - 1);
    k   = lst ? last_keep[p] : '1;
    u   = lst ? last_user[p] : salt[p][bi];
    return {d, k, lst, u};
  endfunction

  task automatic newPacket(input int p);
    has_pkt[p]   = 1'b1;
    hdr_sent[p]  = 1'b0;
    beat[p]      = 0;
    seq[p]       = seq[p] + 1;
    nbeats[p]    = (fixed_len > 0) ? fixed_len : 1 + int'($urandom_range(4));
    salt[p]      = 16'($urandom);
    last_user[p] = (int'($urandom_range(99)) < p_err);
    last_keep[p] = 8'hff >> $urandom_range(7);
    hdr[p]       = {16'(nbeats[p] * 8), 16'($urandom), 16'($urandom), 32'($urandom),
                    32'hC0A80101 + 32'(p)};
  endtask

  task automatic modelReset();
    owner    = -1;
    in_pld   = 1'b0;
    model_lg = NP - 1;
    for (int p = 0; p < NP; p++) begin
      mpkt[p]    = '0;
      merr[p]    = '0;
      has_pkt[p] = 1'b0;
      hdr_sent[p] = 1'b0;
      beat[p]    = 0;
      nbeats[p]  = 0;
    end
  endtask

  task automatic applyStimulus();
    logic [DW+KW+1:0] f;
    for (int p = 0; p < NP; p++) begin
      f = beat_fields(p, beat[p]);
      s_hdr_valid[p]               = has_pkt[p] && !hdr_sent[p];
      s_hdr_data[p*HW +: HW]       = hdr[p];
      s_payload_tdata[p*DW +: DW]  = f[DW+KW+1:KW+2];
      s_payload_tkeep[p*KW +: KW]  = f[KW+1:2];
      s_payload_tlast[p]           = f[1];
      s_payload_tuser[p]           = f[0];
      s_payload_tvalid[p]          = (has_pkt[p] && (int'($urandom_range(99)) < p_tv)) ||
                                     (stray && p == 0 && !has_pkt[p]);
    end
    m_hdr_ready      = (int'($urandom_range(99)) < p_hr);
    m_payload_tready = toggle_pr ? ~m_payload_tready : (int'($urandom_range(99)) < p_pr);
  endtask

  task automatic checkCycle();
    logic [3*NP+1:0] exp_ctl, obs_ctl;
    logic [NP-1:0]   oh;
    logic [NP*CW-1:0] fp, fe;
    obs_ctl = {grant_onehot, m_hdr_valid, m_payload_tvalid, s_hdr_ready, s_payload_tready};
    exp_ctl = '0;
    if (owner >= 0) begin
      oh = NP'(1) << owner;
      if (!in_pld)
        exp_ctl = {oh, s_hdr_valid[owner], 1'b0, oh & {NP{m_hdr_ready}}, NP'(0)};
      else
        exp_ctl = {oh, 1'b0, s_payload_tvalid[owner], NP'(0), oh & {NP{m_payload_tready}}};
    end
    checkOutput("ctl", 128'(obs_ctl), 128'(exp_ctl));
    if (owner >= 0 && !in_pld && s_hdr_valid[owner])
      checkOutput("hdr", 128'(m_hdr_data), 128'(hdr[owner]));
    if (owner >= 0 && in_pld && s_payload_tvalid[owner])
      checkOutput("beat", 128'({m_payload_tdata, m_payload_tkeep, m_payload_tlast, m_payload_tuser}),
                  128'(beat_fields(owner, beat[owner])));
    for (int p = 0; p < NP; p++) begin
      fp[p*CW +: CW] = mpkt[p];
      fe[p*CW +: CW] = merr[p];
    end
    checkOutput("pkt_cnt", 128'(pkt_count), 128'(fp));
    checkOutput("err_cnt", 128'(err_count), 128'(fe));
  endtask

  // Apply packet-level rules to the handshakes about to happen at the next edge
  task automatic advance();
    bit found;
    int c;
    if (owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        c = (model_lg + k) % NP;
        if (!found && s_hdr_valid[c]) begin
          found = 1'b1;
          owner = c;
          in_pld = 1'b0;
        end
      end
    end else if (!in_pld) begin
      if (s_hdr_valid[owner] && m_hdr_ready) in_pld = 1'b1;
    end else if (s_payload_tvalid[owner] && m_payload_tready && beat[owner] == nbeats[owner] - 1) begin
      mpkt[owner] = mpkt[owner] + 1;
      if (last_user[owner]) merr[owner] = merr[owner] + 1;
      model_lg = owner;
      owner    = -1;
    end
    for (int p = 0; p < NP; p++) begin
      if (s_hdr_valid[p] && s_hdr_ready[p]) hdr_sent[p] = 1'b1;
      if (has_pkt[p] && s_payload_tvalid[p] && s_payload_tready[p]) begin
        if (beat[p] == nbeats[p] - 1) has_pkt[p] = 1'b0;
        else beat[p] = beat[p] + 1;
      end
      if (!has_pkt[p] && int'($urandom_range(99)) < p_new) newPacket(p);
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      checkCycle();
      advance();
      @(posedge clk);
      #1;
      applyStimulus();
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    modelReset();
    applyStimulus();
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus();
  endtask

  initial begin
    bit hit;
    for (int p = 0; p < NP; p++) seq[p] = 0;
    modelReset();
    rst = 1'b1;
    applyStimulus();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus();

    // Payload valid with no header request must not win a grant
    stray = 1'b1;
    runCycles(10);
    stray = 1'b0;

    p_new = 10;
    runCycles(300);

    p_new = 100; p_tv = 100; p_hr = 100; p_pr = 100;
    runCycles(300);

    p_hr = 0;
    runCycles(10);
    p_hr = 100; toggle_pr = 1'b1;
    runCycles(200);
    toggle_pr = 1'b0;

    p_tv = 70; p_hr = 60; p_pr = 60; p_err = 50; p_new = 30;
    runCycles(2000);

    // Reset in the middle of a 5-beat packet
    fixed_len = 5; p_tv = 100; p_pr = 100; p_hr = 100; p_new = 100;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      runCycles(1);
      if (owner >= 0 && in_pld && beat[owner] >= 1) hit = 1'b1;
    end
    checkOutput("rst_wait", 128'(hit), 128'(1));
    p_new = 0;
    doReset();
    runCycles(2);
    for (int p = 0; p < NP; p++) newPacket(p);
    applyStimulus();
    runCycles(40);

    fixed_len = 0; p_new = 40; p_tv = 80; p_hr = 70; p_pr = 70;
    runCycles(500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
Packet-atomic round-robin arbiter that shares one UDP transmit path (112-bit header stream plus 64-bit AXI-Stream payload) between NUM_PORTS requesters. Typical requesters are the reliable-transport data path and the ACK/NACK generator, both feeding the fpga_core UDP input.
Each packet is a header followed by a tlast-terminated payload. The block grants one port at a time, forwards exactly one header and its payload, then re-arbitrates. It also keeps per-port packet counts and a per-port count of packets with errors (tuser set).

Parameters:
NUM_PORTS, 2, number of requesters (2..8)
HDR_WIDTH, 112, header width: {length[16], dest_port[16], src_port[16], dest_ip[32], src_ip[32]}, src_ip in LSBs
DATA_WIDTH, 64, payload tdata width
KEEP_WIDTH, DATA_WIDTH/8, payload tkeep width
CNT_WIDTH, 32, statistics counter width

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
s_hdr_data  in  NUM_PORTS*HDR_WIDTH  per-port headers; port i uses slice [i*HDR_WIDTH +: HDR_WIDTH]
s_hdr_valid  in  NUM_PORTS  per-port header valid
s_hdr_ready  out  NUM_PORTS  per-port header ready
s_payload_tdata  in  NUM_PORTS*DATA_WIDTH  per-port payload data
s_payload_tkeep  in  NUM_PORTS*KEEP_WIDTH  per-port byte enables
s_payload_tlast  in  NUM_PORTS  per-port end of packet
s_payload_tuser  in  NUM_PORTS  per-port error flag, sampled on the tlast beat
s_payload_tvalid  in  NUM_PORTS  per-port payload valid
s_payload_tready  out  NUM_PORTS  per-port payload ready
m_hdr_data  out  HDR_WIDTH  granted header
m_hdr_valid  out  1  header valid
m_hdr_ready  in  1  downstream header ready
m_payload_tdata  out  DATA_WIDTH  granted payload data
m_payload_tkeep  out  KEEP_WIDTH  granted payload byte enables
m_payload_tlast  out  1  granted payload end of packet
m_payload_tuser  out  1  granted payload error flag
m_payload_tvalid  out  1  payload valid
m_payload_tready  in  1  downstream payload ready
grant_onehot  out  NUM_PORTS  current grant; 0 when idle
pkt_count  out  NUM_PORTS*CNT_WIDTH  per-port count of completed packets
err_count  out  NUM_PORTS*CNT_WIDTH  per-port count of packets whose tlast beat had tuser=1

Behaviour:
- States: IDLE, HDR, PLD. Registers: state, grant index g, last-served index lg, and the counters.
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE, g=0, lg=NUM_PORTS-1 so port 0 wins first, all counters 0.
  - While in IDLE all s_*_ready=0, m_hdr_valid=0, m_payload_tvalid=0, grant_onehot=0.
  - The m_* data outputs are muxed from g and are don't-care while their valid is low.
- IDLE:
  - If any s_hdr_valid is set, pick the first set bit searching from lg+1 upward modulo NUM_PORTS.
  - Load g with that port and go to HDR. Otherwise stay in IDLE.
  - Arbitration looks only at s_hdr_valid; payload valid without header valid does not request.
- HDR (combinational pass-through of port g only):
  - m_hdr_data=s_hdr_data[g], m_hdr_valid=s_hdr_valid[g], s_hdr_ready[g]=m_hdr_ready.
  - All other readies are 0, and m_payload_tvalid=0.
  - On m_hdr_valid&m_hdr_ready go to PLD.
- PLD (combinational pass-through of port g only):
  - Payload fields muxed from port g; s_payload_tready[g]=m_payload_tready.
  - m_hdr_valid=0 and every s_hdr_ready=0.
  - On a handshake with tlast=1:
    - increment pkt_count[g];
    - increment err_count[g] if tuser=1;
    - set lg<=g and go to IDLE.
  - Beats with tlast=0 stay in PLD.
- grant_onehot = one-hot of g in HDR and PLD, 0 in IDLE.
- Latency:
  - Header is presented on the cycle after the request is first seen in IDLE.
  - No added latency on payload beats (zero-cycle pass-through).
  - Between a tlast handshake and the next header handshake there is a minimum 2-cycle gap (one IDLE cycle, then HDR).
- Packet atomicity:
  - The grant never changes between header acceptance and the tlast handshake, even if higher-index ports are waiting.
  - A deasserted s_payload_tvalid[g] stalls the output and does not release the grant.
- Counters wrap modulo 2^CNT_WIDTH without saturation.
- Single-beat packets (first beat has tlast=1) are legal.
- Reset mid-packet: the block returns to IDLE and aborts the packet. Downstream may see a truncated packet. The upstream sources are reset by the same rst.

Test Plan:
- Single packet on port 1 only (header length=24, 3 beats, last beat tlast=1, data 0x0f0f0f0f0f0f0f0f) -> header out with src_ip 192.168.1.2 unchanged; 3 payload beats in order; pkt_count[1]=1, pkt_count[0]=0; grant_onehot=2'b10 during the packet, 0 after.
- Ports 0 and 1 each hold 3 packets of 5 beats, requesting continuously -> output port order 0,1,0,1,0,1; no beats interleave between packets; both pkt_counts=3.
- Backpressure: m_hdr_ready held low for 10 cycles, then m_payload_tready toggled every cycle -> s_hdr_ready stays 0 during the stall; every beat is delivered exactly once in order; port 0 raising a request mid-packet is not granted until after the port-1 tlast.
- Port 0 asserts s_payload_tvalid with s_hdr_valid=0 -> grant_onehot stays 0, s_payload_tready[0]=0, no output valid.
- Port 0 packet ends with tuser=1 on its tlast beat -> m_payload_tuser=1 on that beat; err_count[0]=1, pkt_count[0]=1.
- rst asserted for 1 cycle during beat 2 of a 5-beat packet -> next cycle all readies and valids are 0, counters are 0; the next request is served by port 0 first.
